// File: rtl/bsg_fpu_i2f_iter_e_p5_m_p10_if.sv
// Handshake bundle for the iterative int-to-binary16 converter.
// The master side supplies operands and consumes results; the slave side is the converter.
interface bsg_fpu_i2f_iter_e_p5_m_p10_if;
  logic        v_i;
  logic [15:0] a_i;
  logic        signed_i;
  logic        ready_o;
  logic        v_o;
  logic [15:0] z_o;
  logic        inexact_o;
  logic        yumi_i;

  modport master (
    output v_i, a_i, signed_i, yumi_i,
    input  ready_o, v_o, z_o, inexact_o
  );

  modport slave (
    input  v_i, a_i, signed_i, yumi_i,
    output ready_o, v_o, z_o, inexact_o
  );
endinterface

// File: rtl/bsg_fpu_i2f_iter_e_p5_m_p10.sv
// Iterative 16-bit integer to IEEE-754 binary16 converter, round-to-nearest-even.
// Normalises one bit per cycle so only a single shifter slice is needed.
module bsg_fpu_i2f_iter_e_p5_m_p10 (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  bsg_fpu_i2f_iter_e_p5_m_p10_if.slave        io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_r;
  logic        sign_r;
  logic [15:0] mag_r;
  logic [3:0]  pos_r;
  logic [15:0] z_r;
  logic        inexact_r;
  logic        ready_r;
  logic        v_r;

  // Operand capture path: sign and magnitude of the incoming integer.
  logic        in_sign;
  logic [15:0] in_mag;

  // Rounding path, evaluated once the leading one sits in mag_r[15].
  logic [9:0]  man;
  logic        guard;
  logic        sticky;
  logic        rup;
  logic [4:0]  exp_pre;
  logic [14:0] rounded;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    in_sign = 1'b0;
    in_mag  = io.a_i;
    in_sign = io.signed_i & io.a_i[15];
    // 0x8000 negates to itself, which is the right unsigned magnitude.
    if (in_sign) in_mag = ~io.a_i + 16'd1;
  end

  always_comb begin
    man     = mag_r[14:5];
    guard   = mag_r[4];
    sticky  = |mag_r[3:0];
    rup     = guard & (sticky | man[0]);
    exp_pre = {1'b0, pos_r} + 5'd15;
    // A mantissa carry ripples into the exponent; from exp 30 it lands on infinity.
    rounded = {exp_pre, man} + {14'd0, rup};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      sign_r    <= 1'b0;
      mag_r     <= 16'd0;
      pos_r     <= 4'd0;
      z_r       <= 16'd0;
      inexact_r <= 1'b0;
      ready_r   <= 1'b1;
      v_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (io.v_i && ready_r) begin
            sign_r  <= in_sign;
            mag_r   <= in_mag;
            pos_r   <= 4'd15;
            ready_r <= 1'b0;
            if (in_mag == 16'd0) begin
              // Zero skips normalisation; the sign is dropped so -0 never appears.
              z_r       <= 16'h0000;
              inexact_r <= 1'b0;
              v_r       <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r <= NORM;
            end
          end
        end

        NORM: begin
          if (!mag_r[15]) begin
            mag_r <= {mag_r[14:0], 1'b0};
            pos_r <= pos_r - 4'd1;
          end else begin
            z_r       <= {sign_r, rounded};
            inexact_r <= guard | sticky;
            v_r       <= 1'b1;
            state_r   <= DONE;
          end
        end

        DONE: begin
          if (io.yumi_i) begin
            v_r     <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end

        default: begin
          state_r <= IDLE;
          v_r     <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign io.ready_o   = ready_r;
  assign io.v_o       = v_r;
  assign io.z_o       = z_r;
  assign io.inexact_o = inexact_r;

endmodule

// File: tb/tb_bsg_fpu_i2f_iter_e_p5_m_p10.sv
// Directed bench for the iterative int-to-binary16 converter: values, latency,
// backpressure and asynchronous reset, all against hand-computed expectations.
module tb_bsg_fpu_i2f_iter_e_p5_m_p10;

  logic clk_i;
  logic reset_n_i;
  int   total;
  int   bad;

  bsg_fpu_i2f_iter_e_p5_m_p10_if io ();

  bsg_fpu_i2f_iter_e_p5_m_p10 dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .io        (io)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present an operand and return once the acceptance edge (E0) has passed.
  task automatic start(input logic [15:0] a, input logic sgn, input string tag);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!io.ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check({tag, " ready timeout"}, 32'd0, 32'd1);
    io.v_i      = 1'b1;
    io.a_i      = a;
    io.signed_i = sgn;
    @(posedge clk_i);
    #1;
    io.v_i = 1'b0;
    io.a_i = 16'h5A5A;
  endtask

  // Count edges after E0 until v_o is seen; leaves the bench at a negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk_i);
    while (!io.v_o && lat < 40) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
  endtask

  task automatic pop(input string tag);
    io.yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    io.yumi_i = 1'b0;
    @(negedge clk_i);
    check({tag, " ready after yumi"}, 32'(io.ready_o), 32'd1);
    check({tag, " v_o after yumi"}, 32'(io.v_o), 32'd0);
  endtask

  task automatic convert(input logic [15:0] a, input logic sgn, input logic [15:0] exp_z,
                         input logic exp_inx, input int exp_lat, input string tag);
    int lat;
    start(a, sgn, tag);
    wait_result(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " v_o"}, 32'(io.v_o), 32'd1);
    check({tag, " z_o"}, 32'(io.z_o), 32'(exp_z));
    check({tag, " inexact"}, 32'(io.inexact_o), 32'(exp_inx));
    pop(tag);
  endtask

  initial begin
    int lat;
    total       = 0;
    bad         = 0;
    io.v_i      = 1'b0;
    io.a_i      = 16'h0000;
    io.signed_i = 1'b0;
    io.yumi_i   = 1'b0;
    reset_n_i   = 1'b0;

    #12;
    check("reset ready", 32'(io.ready_o), 32'd1);
    check("reset v_o", 32'(io.v_o), 32'd0);
    check("reset z_o", 32'(io.z_o), 32'd0);
    check("reset inexact", 32'(io.inexact_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    convert(16'h0001, 1'b0, 16'h3C00, 1'b0, 16, "u1");
    convert(16'hFFFF, 1'b1, 16'hBC00, 1'b0, 16, "s-1");
    convert(16'h8000, 1'b1, 16'hF800, 1'b0, 1,  "s-32768");
    convert(16'h8000, 1'b0, 16'h7800, 1'b0, 1,  "u32768");
    convert(16'h0801, 1'b0, 16'h6800, 1'b1, 5,  "u2049 tie");
    convert(16'h0803, 1'b0, 16'h6802, 1'b1, 5,  "u2051 up");
    convert(16'hFFFF, 1'b0, 16'h7C00, 1'b1, 1,  "u65535 inf");
    convert(16'h0000, 1'b1, 16'h0000, 1'b0, 0,  "s0");
    convert(16'h0400, 1'b1, 16'h6400, 1'b0, 6,  "s1024");
    convert(16'hFFF0, 1'b1, 16'hCC00, 1'b0, 12, "s-16");

    // Backpressure: result must hold while the producer wiggles its inputs.
    start(16'h0803, 1'b0, "bp");
    wait_result(lat);
    check("bp latency", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      io.v_i      = i[0];
      io.a_i      = 16'h1234 + 16'(i);
      io.signed_i = i[1];
      @(posedge clk_i);
      @(negedge clk_i);
      check("bp v_o", 32'(io.v_o), 32'd1);
      check("bp ready", 32'(io.ready_o), 32'd0);
      check("bp z_o", 32'(io.z_o), 32'h6802);
      check("bp inexact", 32'(io.inexact_o), 32'd1);
    end
    io.v_i = 1'b0;
    pop("bp");

    // Asynchronous reset four cycles into a long normalisation.
    start(16'h0001, 1'b0, "rst");
    repeat (3) @(posedge clk_i);
    #3;
    check("rst pre v_o", 32'(io.v_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    check("rst v_o", 32'(io.v_o), 32'd0);
    check("rst ready", 32'(io.ready_o), 32'd1);
    check("rst z_o", 32'(io.z_o), 32'd0);
    check("rst inexact", 32'(io.inexact_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    convert(16'h0003, 1'b0, 16'h4200, 1'b0, 15, "u3 after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
